// File: rtl/cpu_defs_pkg.sv
// Shared definitions for the 16-bit CPU: opcodes, write-back source codes,
// control FSM states and the branch-offset sign extension.
package cpu_defs;

    typedef enum logic [2:0] {
        OpAdd  = 3'b000,
        OpSub  = 3'b001,
        OpNop  = 3'b010,
        OpHalt = 3'b011,
        OpOut  = 3'b100,
        OpLdi  = 3'b101,
        OpJump = 3'b110,
        OpRep  = 3'b111
    } opcode_e;

    typedef enum logic [1:0] {
        WbAlu  = 2'b00,
        WbImm  = 2'b01,
        WbRdB  = 2'b10,
        WbTemp = 2'b11
    } wb_sel_e;

    typedef enum logic [2:0] {
        StFetch   = 3'd0,
        StExec    = 3'd1,
        StSwap    = 3'd2,
        StOutWait = 3'd3,
        StHalt    = 3'd4
    } state_e;

    function automatic logic [15:0] sext10(input logic [9:0] v);
        return {{6{v[9]}}, v};
    endfunction

endpackage

// File: rtl/instr_decode.sv
// Combinational field extraction and opcode decode of the instruction register.
module instr_decode
    import cpu_defs::*;
(
    input  logic [15:0] ir_i,
    output opcode_e     opcode_o,
    output logic [2:0]  rd_o,
    output logic [2:0]  rs_o,
    output logic [15:0] imm_o,
    output logic [15:0] offset_o
);

    assign opcode_o = opcode_e'(ir_i[15:13]);
    assign rd_o     = ir_i[12:10];
    assign rs_o     = ir_i[9:7];
    assign imm_o    = {6'b0, ir_i[9:0]};
    assign offset_o = sext10(ir_i[9:0]);

endmodule

// File: rtl/control_unit.sv
// Multi-cycle control unit: fetch/execute FSM, PC, IR, swap temp and the
// ready/valid output port.
module control_unit
    import cpu_defs::*;
#(
    parameter logic [15:0] PC_RESET = 16'h0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic [15:0] pc,
    input  logic [15:0] instruction,
    output logic [2:0]  rf_raddr_a,
    output logic [2:0]  rf_raddr_b,
    input  logic [15:0] rf_rdata_a,
    output logic        rf_we,
    output logic [2:0]  rf_waddr,
    output logic [1:0]  wb_sel,
    output logic        alu_op,
    output logic [15:0] imm,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_data,
    output logic        halted,
    output logic [15:0] swap_temp
);

    state_e      state_q, state_d;
    logic [15:0] pc_q, pc_d;
    logic [15:0] ir_q, ir_d;
    logic [15:0] temp_q, temp_d;
    logic [15:0] out_data_q, out_data_d;
    logic        out_valid_q, out_valid_d;
    logic        halted_q, halted_d;

    opcode_e     opcode;
    logic [2:0]  rd;
    logic [2:0]  rs;
    logic [15:0] offset;
    logic [15:0] pc_inc;
    wb_sel_e     wb_sel_c;

    instr_decode u_decode (
        .ir_i     (ir_q),
        .opcode_o (opcode),
        .rd_o     (rd),
        .rs_o     (rs),
        .imm_o    (imm),
        .offset_o (offset)
    );

    assign pc_inc = pc_q + 16'd1;

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        ir_d        = ir_q;
        temp_d      = temp_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        halted_d    = halted_q;
        rf_we       = 1'b0;
        rf_waddr    = rd;
        wb_sel_c    = WbAlu;
        alu_op      = 1'b0;

        unique case (state_q)
            StFetch: begin
                ir_d    = instruction;
                state_d = StExec;
            end
            StExec: begin
                state_d = StFetch;
                pc_d    = pc_inc;
                case (opcode)
                    OpAdd, OpSub: begin
                        rf_we  = 1'b1;
                        alu_op = (opcode == OpSub);
                    end
                    OpLdi: begin
                        rf_we    = 1'b1;
                        wb_sel_c = WbImm;
                    end
                    OpNop: ;
                    OpJump: begin
                        // Offset is relative to the jump's own address.
                        if (rf_rdata_a == 16'h0000) begin
                            pc_d = pc_q + offset;
                        end
                    end
                    OpRep: begin
                        rf_we    = 1'b1;
                        wb_sel_c = WbRdB;
                        temp_d   = rf_rdata_a;
                        pc_d     = pc_q;
                        state_d  = StSwap;
                    end
                    OpOut: begin
                        out_data_d  = rf_rdata_a;
                        out_valid_d = 1'b1;
                        pc_d        = pc_q;
                        state_d     = StOutWait;
                    end
                    OpHalt: begin
                        halted_d = 1'b1;
                        pc_d     = pc_q;
                        state_d  = StHalt;
                    end
                endcase
            end
            StSwap: begin
                rf_we    = 1'b1;
                rf_waddr = rs;
                wb_sel_c = WbTemp;
                pc_d     = pc_inc;
                state_d  = StFetch;
            end
            StOutWait: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    pc_d        = pc_inc;
                    state_d     = StFetch;
                end
            end
            StHalt: ;
            default: state_d = StFetch;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StFetch;
            pc_q        <= PC_RESET;
            ir_q        <= 16'h0000;
            temp_q      <= 16'h0000;
            out_data_q  <= 16'h0000;
            out_valid_q <= 1'b0;
            halted_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            ir_q        <= ir_d;
            temp_q      <= temp_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            halted_q    <= halted_d;
        end
    end

    assign pc         = pc_q;
    assign rf_raddr_a = ir_q[12:10];
    assign rf_raddr_b = ir_q[9:7];
    assign wb_sel     = wb_sel_c;
    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign halted     = halted_q;
    assign swap_temp  = temp_q;

endmodule

// File: tb/tb_control_unit.sv
// Bench for control_unit: a small datapath around the DUT plus an
// instruction-level model of the ISA, compared every cycle.
module tb_control_unit;

    localparam logic [2:0]  OpcAdd  = 3'd0;
    localparam logic [2:0]  OpcSub  = 3'd1;
    localparam logic [2:0]  OpcNop  = 3'd2;
    localparam logic [2:0]  OpcHalt = 3'd3;
    localparam logic [2:0]  OpcOut  = 3'd4;
    localparam logic [2:0]  OpcLdi  = 3'd5;
    localparam logic [2:0]  OpcRep  = 3'd7;
    localparam logic [15:0] Halt    = 16'h6000;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [15:0] pc, instruction, rf_rdata_a, rf_rdata_b, imm, out_data, swap_temp;
    logic [2:0]  rf_raddr_a, rf_raddr_b, rf_waddr;
    logic [1:0]  wb_sel;
    logic        rf_we, alu_op, out_valid, out_ready, halted;
    logic [15:0] wdata;

    logic [15:0] w_pc, w_imm, w_out_data, w_temp;
    logic [2:0]  w_raddr_a, w_raddr_b, w_waddr;
    logic [1:0]  w_wb_sel;
    logic        w_we, w_alu_op, w_out_valid, w_halted;

    always #5 clk = ~clk;

    control_unit u_dut (
        .clk(clk), .reset(reset), .pc(pc), .instruction(instruction),
        .rf_raddr_a(rf_raddr_a), .rf_raddr_b(rf_raddr_b), .rf_rdata_a(rf_rdata_a),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .wb_sel(wb_sel), .alu_op(alu_op), .imm(imm),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .halted(halted), .swap_temp(swap_temp)
    );

    control_unit #(.PC_RESET(16'hFFFF)) u_wrap (
        .clk(clk), .reset(reset), .pc(w_pc), .instruction(16'h4000),
        .rf_raddr_a(w_raddr_a), .rf_raddr_b(w_raddr_b), .rf_rdata_a(16'h0000),
        .rf_we(w_we), .rf_waddr(w_waddr), .wb_sel(w_wb_sel), .alu_op(w_alu_op), .imm(w_imm),
        .out_valid(w_out_valid), .out_ready(1'b0), .out_data(w_out_data),
        .halted(w_halted), .swap_temp(w_temp)
    );

    // Datapath: instruction memory (aliased to 64 words), register file, ALU.
    logic [15:0] imem [64];
    logic [15:0] rf [8];
    assign instruction = imem[pc[5:0]];
    assign rf_rdata_a  = rf[rf_raddr_a];
    assign rf_rdata_b  = rf[rf_raddr_b];

    always_comb begin
        wdata = 16'h0000;
        case (wb_sel)
            2'd0: wdata = alu_op ? rf_rdata_a - rf_rdata_b : rf_rdata_a + rf_rdata_b;
            2'd1: wdata = imm;
            2'd2: wdata = rf_rdata_b;
            default: wdata = swap_temp;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rf_we) rf[rf_waddr] <= wdata;
    end

    logic [15:0] dut_q[$];
    initial forever begin
        @(posedge clk);
        if (!reset && out_valid && out_ready) dut_q.push_back(out_data);
    end

    // Instruction-level model: m_e counts cycles spent in the current instruction.
    logic [15:0] m_rf [8];
    logic [15:0] m_pc = 16'h0000;
    logic [15:0] m_ir = 16'h0000;
    logic [15:0] m_temp, m_out;
    int          m_e = 0;
    logic [15:0] exp_q[$];

    initial forever begin
        logic [2:0] op, rd, rs;
        @(posedge clk or posedge reset);
        if (reset) begin
            m_pc = 16'h0000;
            m_e  = 0;
        end else if (m_e == 0) begin
            m_ir = imem[m_pc[5:0]];
            m_e  = 1;
        end else begin
            op = m_ir[15:13];
            rd = m_ir[12:10];
            rs = m_ir[9:7];
            if (m_e == 1) begin
                m_e = 0;
                m_pc = m_pc + 16'd1;
                case (op)
                    3'd0: m_rf[rd] = m_rf[rd] + m_rf[rs];
                    3'd1: m_rf[rd] = m_rf[rd] - m_rf[rs];
                    3'd5: m_rf[rd] = {6'd0, m_ir[9:0]};
                    3'd6: if (m_rf[rd] == 16'h0000)
                              m_pc = m_pc - 16'd1 + {{6{m_ir[9]}}, m_ir[9:0]};
                    3'd3: begin m_pc = m_pc - 16'd1; m_e = 2; end
                    3'd4: begin m_pc = m_pc - 16'd1; m_out = m_rf[rd]; m_e = 2; end
                    3'd7: begin
                        m_pc = m_pc - 16'd1;
                        m_temp = m_rf[rd];
                        m_rf[rd] = m_rf[rs];
                        m_e = 2;
                    end
                    default: ;
                endcase
            end else if (op == 3'd7) begin
                m_rf[rs] = m_temp;
                m_pc = m_pc + 16'd1;
                m_e = 0;
            end else if (op == 3'd4 && out_ready) begin
                exp_q.push_back(m_out);
                m_pc = m_pc + 16'd1;
                m_e = 0;
            end else begin
                m_e = m_e + 1;
            end
        end
    end

    int n_vec = 0;
    int n_bad = 0;
    int dq0, eq0;
    logic [15:0] prog[$];

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_cycle();
        logic [2:0] op;
        logic       exp_we, exp_valid, exp_halt;
        op        = m_ir[15:13];
        exp_valid = (m_e >= 2) && (op == OpcOut);
        exp_halt  = (m_e >= 2) && (op == OpcHalt);
        exp_we    = ((m_e == 1) && (op inside {OpcAdd, OpcSub, OpcLdi, OpcRep}))
                    || ((m_e == 2) && (op == OpcRep));
        chk("pc", pc, m_pc);
        chk("out_valid", 16'(out_valid), 16'(exp_valid));
        chk("halted", 16'(halted), 16'(exp_halt));
        chk("rf_we", 16'(rf_we), 16'(exp_we));
        chk("wrap_rf_we", 16'(w_we), 16'h0);
        chk("wrap_out_valid", 16'(w_out_valid), 16'h0);
        chk("wrap_halted", 16'(w_halted), 16'h0);
        if (exp_we) begin
            chk("rf_waddr", 16'(rf_waddr), 16'((m_e == 2) ? m_ir[9:7] : m_ir[12:10]));
            chk("wb_sel", 16'(wb_sel), (m_e == 2) ? 16'd3 : (op == OpcLdi) ? 16'd1 :
                                       (op == OpcRep) ? 16'd2 : 16'd0);
            if (op inside {OpcAdd, OpcSub}) chk("alu_op", 16'(alu_op), 16'(op == OpcSub));
        end
        if (exp_valid) chk("out_data", out_data, m_out);
        if (m_e == 0 && !reset) begin
            for (int r = 0; r < 8; r++) chk("regfile", rf[r], m_rf[r]);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
        check_cycle();
    endtask

    task automatic start_prog();
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 64; i++) imem[i] = (i < prog.size()) ? prog[i] : Halt;
        cyc();
        reset = 1'b0;
        dq0 = dut_q.size();
        eq0 = exp_q.size();
    endtask

    task automatic run_until_halt(input int budget, input logic [15:0] watch, output int cnt);
        cnt = 0;
        for (int i = 0; i < budget; i++) begin
            cyc();
            if (pc == watch) cnt++;
            if (halted === 1'b1) break;
        end
        chk("halt_reached", 16'(halted), 16'h1);
    endtask

    task automatic check_transfers();
        chk("xfer_count", 16'(dut_q.size() - dq0), 16'(exp_q.size() - eq0));
        for (int i = 0; i < exp_q.size() - eq0 && dq0 + i < dut_q.size(); i++)
            chk("xfer_data", dut_q[dq0 + i], exp_q[eq0 + i]);
    endtask

    function automatic logic [15:0] xfer(input int k);
        return (dut_q.size() > dq0 + k) ? dut_q[dq0 + k] : 16'hxxxx;
    endfunction

    function automatic logic [15:0] f_ldi(input logic [2:0] rd, input int v);
        return {OpcLdi, rd, v[9:0]};
    endfunction
    function automatic logic [15:0] f_rr(input logic [2:0] op, input logic [2:0] rd,
                                         input logic [2:0] rs);
        return {op, rd, rs, 7'd0};
    endfunction
    function automatic logic [15:0] f_jmp(input logic [2:0] rd, input int off);
        return {3'd6, rd, off[9:0]};
    endfunction
    function automatic logic [15:0] f_out(input logic [2:0] rd);
        return {OpcOut, rd, 10'd0};
    endfunction

    initial begin
        int cnt;
        logic [15:0] w;
        out_ready = 1'b1;
        for (int i = 0; i < 64; i++) imem[i] = Halt;
        #1;
        reset = 1'b1;
        #1;
        chk("reset_pc", pc, 16'h0000);
        chk("reset_out_valid", 16'(out_valid), 16'h0);
        chk("reset_halted", 16'(halted), 16'h0);
        chk("reset_rf_we", 16'(rf_we), 16'h0);
        chk("reset_out_data", out_data, 16'h0000);
        chk("wrap_reset_pc", w_pc, 16'hFFFF);
        @(negedge clk);
        reset = 1'b0;
        cyc();
        chk("wrap_pc_fetch", w_pc, 16'hFFFF);
        cyc();
        chk("wrap_pc_after_nop", w_pc, 16'h0000);

        // Multiply 7 x 9 by repeated addition.
        prog = '{f_ldi(1, 7), f_ldi(2, 9), f_ldi(3, 0), f_ldi(4, 1), f_ldi(0, 0),
                 f_jmp(1, 4), f_rr(OpcAdd, 3, 2), f_rr(OpcSub, 1, 4), f_jmp(0, -3),
                 f_out(3), Halt};
        start_prog();
        run_until_halt(400, 16'hFFFF, cnt);
        check_transfers();
        chk("mul_xfer_count", 16'(dut_q.size() - dq0), 16'd1);
        chk("mul_product", xfer(0), 16'd63);
        chk("mul_halt_pc", pc, 16'h000A);

        // Register swap.
        prog = '{f_ldi(0, 18), f_ldi(1, 10), f_rr(OpcRep, 0, 1), f_out(0), f_out(1), Halt};
        start_prog();
        run_until_halt(100, 16'h0002, cnt);
        check_transfers();
        chk("rep_cycles", 16'(cnt), 16'd3);
        chk("rep_xfer0", xfer(0), 16'd10);
        chk("rep_xfer1", xfer(1), 16'd18);

        // Output back-pressure.
        out_ready = 1'b0;
        prog = '{f_ldi(5, 16'h155), f_out(5), Halt};
        start_prog();
        for (int i = 0; i < 20 && out_valid !== 1'b1; i++) cyc();
        for (int i = 0; i < 5; i++) begin
            cyc();
            chk("stall_valid", 16'(out_valid), 16'h1);
            chk("stall_data", out_data, 16'h0155);
            chk("stall_pc", pc, 16'h0001);
        end
        chk("stall_no_xfer", 16'(dut_q.size() - dq0), 16'd0);
        out_ready = 1'b1;
        run_until_halt(20, 16'hFFFF, cnt);
        check_transfers();
        chk("stall_xfer_count", 16'(dut_q.size() - dq0), 16'd1);
        chk("stall_xfer_data", xfer(0), 16'h0155);

        // Conditional jumps, including a backward wrap below address 0.
        prog = '{f_ldi(0, 10), f_jmp(0, 2), Halt, Halt};
        start_prog();
        run_until_halt(20, 16'hFFFF, cnt);
        chk("jump_not_taken_pc", pc, 16'h0002);
        prog = '{f_ldi(0, 0), f_jmp(0, 2), Halt, Halt};
        start_prog();
        run_until_halt(20, 16'hFFFF, cnt);
        chk("jump_taken_pc", pc, 16'h0003);
        prog = '{f_ldi(0, 0), f_jmp(0, -2)};
        start_prog();
        run_until_halt(20, 16'h0000, cnt);
        chk("jump_wrap_pc", pc, 16'hFFFF);

        // Reset while in SWAP: the rs write must be dropped.
        prog = '{f_ldi(0, 18), f_ldi(1, 10), f_rr(OpcRep, 0, 1), Halt};
        start_prog();
        for (int i = 0; i < 20 && !(m_e == 2 && m_ir[15:13] == OpcRep); i++) cyc();
        chk("reached_swap", 16'(rf_we && wb_sel == 2'd3), 16'h1);
        reset = 1'b1;
        #1;
        chk("swap_reset_we", 16'(rf_we), 16'h0);
        chk("swap_reset_pc", pc, 16'h0000);
        cyc();
        chk("swap_reset_rs", rf[1], 16'd10);
        chk("swap_reset_rd", rf[0], 16'd10);
        reset = 1'b0;

        // Reset while in OUT_WAIT: the transfer must not happen.
        out_ready = 1'b0;
        prog = '{f_ldi(2, 5), f_out(2), Halt};
        start_prog();
        for (int i = 0; i < 20 && out_valid !== 1'b1; i++) cyc();
        cyc();
        chk("reached_out_wait", 16'(out_valid), 16'h1);
        out_ready = 1'b1;
        reset = 1'b1;
        #1;
        chk("out_reset_valid", 16'(out_valid), 16'h0);
        chk("out_reset_pc", pc, 16'h0000);
        cyc();
        chk("out_reset_no_xfer", 16'(dut_q.size() - dq0), 16'd0);
        reset = 1'b0;
        run_until_halt(20, 16'hFFFF, cnt);
        check_transfers();

        // Random programs with random back-pressure.
        for (int p = 0; p < 4; p++) begin
            prog.delete();
            for (int r = 0; r < 8; r++) prog.push_back(f_ldi(3'(r), int'($urandom_range(0, 1023))));
            for (int i = 8; i < 64; i++) begin
                w = 16'($urandom);
                if (w[15:13] == OpcHalt && $urandom_range(0, 3) != 0) w[15:13] = OpcNop;
                prog.push_back(w);
            end
            start_prog();
            for (int i = 0; i < 400; i++) begin
                cyc();
                out_ready = 1'($urandom_range(0, 1));
            end
            check_transfers();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/control_unit.md
CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 SHALL have parameter PC_RESET, default 16'h0000: PC value loaded on reset.
REQ-002 SHALL have port clk  input  1  single system clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port pc  output  16  instruction address to instruction memory.
REQ-005 SHALL have port instruction  input  16  combinational memory data for address pc.
REQ-006 SHALL have port rf_raddr_a  output  3  register-file read address A, equal to IR[12:10].
REQ-007 SHALL have port rf_raddr_b  output  3  register-file read address B, equal to IR[9:7].
REQ-008 SHALL have port rf_rdata_a  input  16  combinational read data for rf_raddr_a.
REQ-009 SHALL have port rf_we  output  1  register-file write enable, sampled at the clk edge.
REQ-010 SHALL have port rf_waddr  output  3  register-file write address.
REQ-011 SHALL have port wb_sel  output  2  write source: 00 ALU, 01 immediate, 10 read data B, 11 swap temp.
REQ-012 SHALL have port alu_op  output  1  0 = add A+B, 1 = sub A-B.
REQ-013 SHALL have port imm  output  16  IR[9:0] zero-extended.
REQ-014 SHALL have port out_valid  output  1  output-port data valid.
REQ-015 SHALL have port out_ready  input  1  output-port consumer ready.
REQ-016 SHALL have port out_data  output  16  registered value of the out source register.
REQ-017 SHALL have port halted  output  1  high while in HALT.

Function
REQ-018 Decoding SHALL use opcode IR[15:13]: 000 add, 001 sub, 010 nop, 011 halt, 100 out, 101 ldi, 110 jump, 111 rep.
REQ-019 Operand fields SHALL be rd = IR[12:10], rs = IR[9:7], imm10/off10 = IR[9:0].
REQ-020 The FSM SHALL have states FETCH, EXEC, SWAP, OUT_WAIT, and HALT.
REQ-021 In FETCH, the block SHALL latch instruction into IR and go to EXEC, with rf_we=0.
REQ-022 In EXEC, add/sub SHALL set rf_we=1, rf_waddr=rd, wb_sel=00, and alu_op=opcode[0], then pc<=pc+1 and go to FETCH (2 cycles total).
REQ-023 In EXEC, ldi SHALL set rf_we=1, rf_waddr=rd, and wb_sel=01, then pc<=pc+1 and go to FETCH.
REQ-024 In EXEC, jump SHALL set pc<=pc+sext(off10) if rf_rdata_a==0, else pc<=pc+1, then go to FETCH; the offset is relative to the jump's own address.
REQ-025 In EXEC, rep SHALL write rd<=rs (wb_sel=10), latch rf_rdata_a into temp, and go to SWAP.
REQ-026 In SWAP, the block SHALL write rs<=temp (rf_waddr=IR[9:7], wb_sel=11), then pc<=pc+1 and go to FETCH (3 cycles total).
REQ-027 In EXEC, out SHALL load out_data<=rf_rdata_a and go to OUT_WAIT.
REQ-028 In OUT_WAIT, out_valid SHALL be 1 and out_data SHALL be held stable; the transfer completes on the edge with out_ready=1, then pc<=pc+1 and go to FETCH.
REQ-029 out_valid SHALL NOT depend combinationally on out_ready; out_ready high before out_valid SHALL have no effect.
REQ-030 In EXEC, halt SHALL go to HALT; pc SHALL be frozen at the halt address, halted=1, no writes occur, and HALT SHALL exit only via reset.
REQ-031 nop SHALL execute as pc<=pc+1 with no write.
REQ-032 PC arithmetic SHALL be modulo 2^16: 16'hFFFF+1 wraps to 16'h0000, and negative offsets wrap likewise.
REQ-033 rf_we SHALL be 1 only in EXEC for add/sub/ldi/rep and in SWAP.

Reset
REQ-034 On reset assertion, the block SHALL immediately set state=FETCH, pc=PC_RESET, IR=0, temp=0, out_data=0, out_valid=0, rf_we=0, and halted=0.
REQ-035 Reset mid-instruction, including SWAP and OUT_WAIT, SHALL abort the instruction without the pending write or transfer.

Structure
REQ-036 Opcode constants, wb_sel codes, and state encodings SHALL reside in a shared package/include (cpu_defs) used with the ALU and register file.
REQ-037 Field extraction and opcode decode SHALL be a combinational sub-module instr_decode; the FSM, PC, IR, and temp stay in control_unit.

Verification
REQ-038 The bench SHALL run the multiply program (ldi r1,7; ldi r2,9; ldi r3,0; ldi r4,1; ldi r0,0; jump r1,+4; add r3,r2; sub r1,r4; jump r0,-3; out r3; halt) with out_ready=1 and require exactly one transfer out_data=63, then halted=1 with pc=16'h000A.
REQ-039 The bench SHALL run r0=18, r1=10, rep r0,r1, out r0, out r1 and require transfers 10 then 18, with rep taking 3 cycles.
REQ-040 The bench SHALL hold out_ready=0 for 5 cycles during an out and require out_valid held, out_data stable, and pc unchanged, with exactly one transfer once out_ready=1.
REQ-041 The bench SHALL run jump r0,+2 with r0=10 and require pc+1, and with r0=0 require pc+2; it SHALL also run PC_RESET=16'hFFFF with a nop and require pc to wrap to 16'h0000.
REQ-042 The bench SHALL assert reset in SWAP and in OUT_WAIT and require no rs write, no transfer, and pc=PC_RESET in the same cycle.
